// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: collects ctrl-qualified din bits LSB first into WIDTH-bit words.
// Optional even-parity check after the data bits is enabled by defining SERIAL_WORD_RX_PARITY_EN.
module serial_word_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ctrl,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SERIAL_WORD_RX_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               perr_q, perr_d;

  logic [WIDTH-1:0]   new_word;
  logic [WIDTH-1:0]   word;
  logic               word_done;

  // Current shift register with the incoming bit placed at the count position.
  always_comb begin
    new_word = shreg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == CNT_W'(i)) new_word[i] = din;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    perr_d    = 1'b0;
    word      = shreg_q;
    word_done = 1'b0;

    if (valid_q && dout_ready) valid_d = 1'b0;

    if (start) begin
      // Frame (re)alignment wins over any completion in the same cycle.
      state_d = SHIFT;
      shreg_d = '0;
      cnt_d   = '0;
      if (ctrl) begin
        shreg_d[0] = din;
        cnt_d      = CNT_W'(1);
      end
    end else begin
      case (state_q)
        SHIFT: begin
          if (ctrl) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
              shreg_d = new_word;
              cnt_d   = CNT_W'(WIDTH);
              state_d = PARITY;
`else
              word      = new_word;
              word_done = 1'b1;
              shreg_d   = '0;
              cnt_d     = '0;
              state_d   = IDLE;
`endif
            end else begin
              shreg_d = new_word;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef SERIAL_WORD_RX_PARITY_EN
        PARITY: begin
          if (ctrl) begin
            if (^{shreg_q, din} == 1'b0) begin
              word      = shreg_q;
              word_done = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
`endif
        default: ;
      endcase
    end

    if (word_done) begin
      if (!valid_q || dout_ready) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;

endmodule
